// File: rtl/xor_arb_pkg.sv
// Shared constants, FSM state encoding and the round-robin search helper for xor_arbiter.
package xor_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RESP = 1'b1;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;

    // Widest request vector rr_next can search; NUM_REQ must not exceed this.
    localparam int MAX_REQ = 32;

    // Index of the first set bit of req at or after ptr, wrapping modulo n.
    // Scanning from the far end lets the nearest set bit overwrite the result.
    function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int idx;
        rr_next = 0;
        for (int k = n - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (req[idx[4:0]]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/xor_unit.sv
// Combinational DATA_W-wide XOR datapath shared by all requesters.
module xor_unit
    import xor_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_arbiter.sv
// Round-robin arbiter sharing one XOR unit between NUM_REQ valid/ready requesters.
// Optional macro XOR_ARB_LOCK_EN adds req_lock, letting a granted requester keep top priority.
module xor_arbiter
    import xor_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int DATA_W  = DEF_DATA_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
`ifdef XOR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    output logic                      busy
);

    logic               state;
    logic               state_next;
    logic               can_issue;
    logic               grant_en;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_inc;
    logic [ID_W-1:0]    ptr_next;
    logic [MAX_REQ-1:0] valid_ext;
    logic [DATA_W-1:0]  a_sel;
    logic [DATA_W-1:0]  b_sel;
    logic [DATA_W-1:0]  xor_out;

    assign valid_ext = MAX_REQ'(req_valid);
    assign gnt_id    = ID_W'(rr_next(valid_ext, int'(rr_ptr), NUM_REQ));
    // rst_n gates the grant so no handshake can complete while reset is held.
    assign grant_en  = rst_n && can_issue && (|req_valid);
    assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_id) : '0;

    assign a_sel = req_a[gnt_id*DATA_W +: DATA_W];
    assign b_sel = req_b[gnt_id*DATA_W +: DATA_W];

    xor_unit #(.DATA_W(DATA_W)) u_xor (
        .a (a_sel),
        .b (b_sel),
        .y (xor_out)
    );

    always_comb begin
        ptr_inc  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        ptr_next = ptr_inc;
`ifdef XOR_ARB_LOCK_EN
        if (req_lock[gnt_id]) ptr_next = gnt_id;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_en) state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = grant_en ? ST_RESP : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        can_issue = (state == ST_IDLE) || (rsp_ready && (state == ST_RESP));
    end

    // Response registers hold whenever the consumer stalls, since grant_en is then low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (grant_en) begin
            rsp_valid <= 1'b1;
            rsp_data  <= xor_out;
            rsp_id    <= gnt_id;
            rr_ptr    <= ptr_next;
        end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_arbiter.sv
// Directed self-checking bench for xor_arbiter: vector table plus stall, reset and lock sequences.
module tb_xor_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
`ifdef XOR_ARB_LOCK_EN
    logic [3:0]   req_lock;
`endif
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_ready;
    logic         busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]   valid;
        logic [127:0] a;
        logic [127:0] b;
        logic         rdy;
        logic [3:0]   exp_ready;
        logic         exp_valid;
        logic [31:0]  exp_data;
        logic [1:0]   exp_id;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    xor_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
`ifdef XOR_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check the combinational grant, then the registered response.
    task automatic applyStimulus(input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                                 input logic rr, input logic [3:0] er, input logic ev,
                                 input logic [31:0] ed, input logic [1:0] eid, input string tag);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        #1;
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(ev));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(ev));
        if (ev) begin
            checkOutput({tag, ".rsp_data"}, rsp_data, ed);
            checkOutput({tag, ".rsp_id"}, 32'(rsp_id), 32'(eid));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({tag, ".rsp_data"}, rsp_data, 32'h0);
        checkOutput({tag, ".rsp_id"}, 32'(rsp_id), 32'h0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [127:0] a_all;
        logic [127:0] b_all;
        a_all = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        b_all = {32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF};

        vecs[0] = '{4'b1111, a_all, b_all, 1'b1, 4'b0001, 1'b1, 32'h111111EE, 2'd0};
        vecs[1] = '{4'b1111, a_all, b_all, 1'b1, 4'b0010, 1'b1, 32'h2222DD22, 2'd1};
        vecs[2] = '{4'b1111, a_all, b_all, 1'b1, 4'b0100, 1'b1, 32'h33CC3333, 2'd2};
        vecs[3] = '{4'b1111, a_all, b_all, 1'b1, 4'b1000, 1'b1, 32'hBB444444, 2'd3};
        vecs[4] = '{4'b1111, a_all, b_all, 1'b1, 4'b0001, 1'b1, 32'h111111EE, 2'd0};
        vecs[5] = '{4'b0000, a_all, b_all, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0};
        vecs[6] = '{4'b0010, {64'h0, 32'hDEADBEEF, 32'h0}, {64'h0, 32'hDEADBEEF, 32'h0},
                    1'b1, 4'b0010, 1'b1, 32'h00000000, 2'd1};
        vecs[7] = '{4'b1000, {32'hFFFFFFFF, 96'h0}, 128'h0,
                    1'b1, 4'b1000, 1'b1, 32'hFFFFFFFF, 2'd3};
        vecs[8] = '{4'b0011, {96'h0, 32'hFFFF0000}, {96'h0, 32'h0F0F0F0F},
                    1'b1, 4'b0001, 1'b1, 32'hF0F00F0F, 2'd0};
        vecs[9] = '{4'b0000, 128'h0, 128'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0};

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = a_all;
        req_b     = b_all;
        rsp_ready = 1'b1;
`ifdef XOR_ARB_LOCK_EN
        req_lock  = 4'b0000;
`endif
        #1;
        checkResetState("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy, vecs[i].exp_ready,
                          vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_id, $sformatf("vec%0d", i));
        end

        // Consumer stall: response must hold and no grant may issue until rsp_ready returns.
        applyStimulus(4'b0001, {96'h0, 32'h12345678}, 128'h0, 1'b0, 4'b0001, 1'b1,
                      32'h12345678, 2'd0, "stall_grant");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1110, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hCAFEF00D, 32'h0}, 128'h0,
                          1'b0, 4'b0000, 1'b1, 32'h12345678, 2'd0, $sformatf("stall%0d", i));
        end
        applyStimulus(4'b1110, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hCAFEF00D, 32'h0}, 128'h0,
                      1'b1, 4'b0010, 1'b1, 32'hCAFEF00D, 2'd1, "stall_release");
        applyStimulus(4'b0000, 128'h0, 128'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, "stall_drain");

        // Asynchronous reset while a response is pending; rr_ptr was 2 before the pulse.
        applyStimulus(4'b0010, {64'h0, 32'h0000FFFF, 32'h0}, 128'h0, 1'b0, 4'b0010, 1'b1,
                      32'h0000FFFF, 2'd1, "prereset");
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0101, {32'h0, 32'h22, 32'h0, 32'h11}, 128'h0, 1'b1, 4'b0001, 1'b1,
                      32'h00000011, 2'd0, "postreset_ptr");
        applyStimulus(4'b0100, {32'h0, 32'h22, 32'h0, 32'h11}, 128'h0, 1'b1, 4'b0100, 1'b1,
                      32'h00000022, 2'd2, "postreset_req2");
        applyStimulus(4'b0000, 128'h0, 128'h0, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0, "postreset_drain");

`ifdef XOR_ARB_LOCK_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_lock = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0110, {32'h0, 32'h2, 32'h1, 32'h0}, 128'h0, 1'b1, 4'b0010, 1'b1,
                          32'h1, 2'd1, $sformatf("lock%0d", i));
        end
        req_lock = 4'b0000;
        applyStimulus(4'b0110, {32'h0, 32'h2, 32'h1, 32'h0}, 128'h0, 1'b1, 4'b0010, 1'b1,
                      32'h1, 2'd1, "unlock1");
        applyStimulus(4'b0110, {32'h0, 32'h2, 32'h1, 32'h0}, 128'h0, 1'b1, 4'b0100, 1'b1,
                      32'h2, 2'd2, "unlock2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
